// File: rtl/tty_console.sv
`default_nettype none
// ============================================================================
// Module : tty_console
// Brief  : PDP-8 style console teletype. A keyboard device (serial receiver)
//          and a printer device (serial transmitter), both 8N1, driven by
//          IOT instructions. The interrupt request is a level signal.
// Rev    : 1.0  initial release
// ============================================================================
module tty_console #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter logic [5:0]  RX_DEV       = 6'o03,
  parameter logic [5:0]  TX_DEV       = 6'o04
) (
  input  logic        SYSCLK,
  input  logic        RESETn,
  input  logic        IOT,
  input  logic [11:0] IR,
  input  logic [11:0] AC,
  output logic        ACK,
  output logic        SKIP,
  output logic        AC_CLR,
  output logic        AC_OR,
  output logic [11:0] DOUT,
  output logic        IRQ,
  input  logic        RXD,
  output logic        TXD,
  output logic        FERR
);

  localparam int unsigned       CNT_W     = 12;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BRK   = 3'd4;  // bad stop bit: wait for line high

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       iot_ok, kbd_sel, prn_sel;
  logic [2:0] fn;
  logic       ack_d, skip_d, ac_clr_d, ac_or_d;
  logic       kflag_clr, ferr_clr, ie_wr, tflag_set, tflag_clr, tx_go;
  logic       ack_q, skip_q, ac_clr_q, ac_or_q;

  logic       kflag_q, kflag_d, tflag_q, tflag_d, ie_q, ie_d;
  logic       ferr_q, ferr_d, irq_q;
  logic [7:0] rbuf_q, rbuf_d;
  logic [11:0] dout_q;

  logic       rxd_s1_q, rxd_s2_q, rxd_prev_q, rx_fall;
  logic [2:0] rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_done, rx_ferr_set;

  logic [1:0] tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       txd_q, txd_d, tx_done;

  logic       unused_ac;
  assign unused_ac = ^AC[11:8];

  assign fn      = IR[2:0];
  assign iot_ok  = IOT && (IR[11:9] == 3'b110);
  assign kbd_sel = iot_ok && (IR[8:3] == RX_DEV);
  assign prn_sel = iot_ok && (IR[8:3] == TX_DEV) && !kbd_sel;

  // Decode the addressed IOT function into handshake bits and flag actions
  always_comb begin
    ack_d     = kbd_sel | prn_sel;
    skip_d    = 1'b0;
    ac_clr_d  = 1'b0;
    ac_or_d   = 1'b0;
    kflag_clr = 1'b0;
    ferr_clr  = 1'b0;
    ie_wr     = 1'b0;
    tflag_set = 1'b0;
    tflag_clr = 1'b0;
    tx_go     = 1'b0;
    if (kbd_sel) begin
      case (fn)
        3'd0:      begin kflag_clr = 1'b1; ferr_clr = 1'b1; end
        3'd1:      skip_d = kflag_q;
        3'd2,
        3'd3:      begin kflag_clr = 1'b1; ac_clr_d = 1'b1; end
        3'd4:      ac_or_d = 1'b1;
        3'd5:      ie_wr = 1'b1;
        default:   begin kflag_clr = 1'b1; ac_clr_d = 1'b1; ac_or_d = 1'b1; end
      endcase
    end else if (prn_sel) begin
      case (fn)
        3'd0:    tflag_set = 1'b1;
        3'd1:    skip_d = tflag_q;
        3'd2:    tflag_clr = 1'b1;
        3'd4:    tx_go = 1'b1;
        3'd6:    begin tflag_clr = 1'b1; tx_go = 1'b1; end
        default: ;
      endcase
    end
  end

  // Flag updates: a completion (set) always beats a same-cycle clear
  always_comb begin
    kflag_d = rx_done ? 1'b1 : (kflag_clr ? 1'b0 : kflag_q);
    tflag_d = (tx_done || tflag_set) ? 1'b1 : (tflag_clr ? 1'b0 : tflag_q);
    ie_d    = ie_wr ? AC[0] : ie_q;
    ferr_d  = rx_ferr_set ? 1'b1 : (ferr_clr ? 1'b0 : ferr_q);
    rbuf_d  = rx_done ? rx_sh_q : rbuf_q;
  end

  // Handshake outputs, flags, buffers and the RXD synchronizer
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      ack_q      <= 1'b0;
      skip_q     <= 1'b0;
      ac_clr_q   <= 1'b0;
      ac_or_q    <= 1'b0;
      kflag_q    <= 1'b0;
      tflag_q    <= 1'b0;
      ie_q       <= 1'b1;
      ferr_q     <= 1'b0;
      irq_q      <= 1'b0;
      rbuf_q     <= 8'h00;
      dout_q     <= 12'h000;
      // Reset low so a line already low at release is not taken as an edge
      rxd_s1_q   <= 1'b0;
      rxd_s2_q   <= 1'b0;
      rxd_prev_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      skip_q     <= skip_d;
      ac_clr_q   <= ac_clr_d;
      ac_or_q    <= ac_or_d;
      kflag_q    <= kflag_d;
      tflag_q    <= tflag_d;
      ie_q       <= ie_d;
      ferr_q     <= ferr_d;
      irq_q      <= ie_d & (kflag_d | tflag_d);
      rbuf_q     <= rbuf_d;
      // DOUT trails the buffer by one cycle so a read racing a load sees old data
      dout_q     <= {4'h0, rbuf_q};
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  assign rx_fall = rxd_prev_q & ~rxd_s2_q;

  // ---------------------------------------------------------------- receiver
  // Receiver state register
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) rx_state_q <= RX_IDLE;
    else         rx_state_q <= rx_state_d;
  end

  // Receiver next-state logic
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_cnt_q == HALF_LAST) rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt_q == BIT_LAST && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_cnt_q == BIT_LAST) rx_state_d = rxd_s2_q ? RX_IDLE : RX_BRK;
      RX_BRK:   if (rxd_s2_q) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit timer, bit index, shift register, completion
  always_comb begin
    rx_cnt_d    = '0;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_done     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_START: begin
        rx_bit_d = 3'd0;
        if (rx_cnt_q != HALF_LAST) rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_sh_d  = {rxd_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_done     = rxd_s2_q;
          rx_ferr_set = !rxd_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_bit_d = 3'd0;
    endcase
  end

  // Receiver datapath registers
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_cnt_q <= '0;
      rx_bit_q <= 3'd0;
      rx_sh_q  <= 8'h00;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
    end
  end

  // ---------------------------------------------------------------- transmitter
  // Transmitter state register
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) tx_state_q <= TX_IDLE;
    else         tx_state_q <= tx_state_d;
  end

  // Transmitter next-state logic; a start request outside IDLE is ignored
  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:  if (tx_go) tx_state_d = TX_START;
      TX_START: if (tx_cnt_q == BIT_LAST) tx_state_d = TX_DATA;
      TX_DATA:  if (tx_cnt_q == BIT_LAST && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      TX_STOP:  if (tx_cnt_q == BIT_LAST) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Transmitter datapath: bit timer, shifter and registered serial output
  always_comb begin
    tx_cnt_d = '0;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_done  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_bit_d = 3'd0;
        txd_d    = 1'b1;
        if (tx_go) begin
          tx_sh_d = AC[7:0];
          txd_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) txd_d = tx_sh_q[0];
        else                      tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            tx_sh_d = {1'b0, tx_sh_q[7:1]};
            txd_d   = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) tx_done = 1'b1;
        else                      tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    endcase
  end

  // Transmitter datapath registers
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      tx_cnt_q <= '0;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
    end
  end

  assign ACK    = ack_q;
  assign SKIP   = skip_q;
  assign AC_CLR = ac_clr_q;
  assign AC_OR  = ac_or_q;
  assign DOUT   = dout_q;
  assign IRQ    = irq_q;
  assign TXD    = txd_q;
  assign FERR   = ferr_q;

endmodule
`default_nettype wire
